mdu_issue_ctrl: RTL and testbench

- E-stage front end of the multiply/divide unit; sits directly upstream of the MDU.
- Registers MDU operations and operands from D stage and drives the MDU enable, opcode and operand inputs.
- Tracks MDU occupancy with its own countdown and raises stall_d so no MDU instruction enters E while a multiply or divide is in flight.

---
 rtl/mdu_issue_if.sv | 28 ++
 rtl/mdu_issue_ctrl.sv | 137 +++++++++++++
 tb/tb_mdu_issue_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_issue_if.sv
// D-stage to MDU issue bundle: D-stage request/operands in, MDU drive and
// occupancy status out.
interface mdu_issue_if #(
    parameter int CNT_W = 5
) ();
    logic             d_valid;
    logic [3:0]       d_mdu_op;
    logic [31:0]      d_rs_val;
    logic [31:0]      d_rt_val;
    logic             e_hold;
    logic             en_mdu;
    logic [3:0]       mdu_op;
    logic [31:0]      mdu_d1;
    logic [31:0]      mdu_d2;
    logic             stall_d;
    logic             busy;
    logic [CNT_W-1:0] cnt;

    modport slave (
        input  d_valid, d_mdu_op, d_rs_val, d_rt_val, e_hold,
        output en_mdu, mdu_op, mdu_d1, mdu_d2, stall_d, busy, cnt
    );

    modport master (
        output d_valid, d_mdu_op, d_rs_val, d_rt_val, e_hold,
        input  en_mdu, mdu_op, mdu_d1, mdu_d2, stall_d, busy, cnt
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue control for the multiply/divide unit with occupancy countdown.
// Optional stall performance counter enabled by defining MDU_STALL_PERF_EN.
module mdu_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    mdu_issue_if.slave  bus
`ifdef MDU_STALL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd0;
    localparam logic [3:0] OP_MULTU = 4'd1;
    localparam logic [3:0] OP_DIV   = 4'd2;
    localparam logic [3:0] OP_DIVU  = 4'd3;
    localparam logic [3:0] OP_MFHI  = 4'd6;
    localparam logic [3:0] OP_MFLO  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_NOP   = 4'd15;

    // Occupancy loaded into the countdown when an op issues.
    function automatic logic [CNT_W-1:0] busy_cycles(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU: return CNT_W'(MULT_CYCLES);
            OP_DIV, OP_DIVU:   return CNT_W'(DIV_CYCLES);
            default:           return {CNT_W{1'b0}};
        endcase
    endfunction

    // HI/LO reads are signalled to the MDU by a low enable.
    function automatic logic op_enables_mdu(input logic [3:0] op);
        case (op)
            OP_MFHI, OP_MFLO: return 1'b0;
            default:          return 1'b1;
        endcase
    endfunction

    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             en_q,     en_d;
    logic [3:0]       op_q,     op_d;
    logic [31:0]      d1_q,     d1_d;
    logic [31:0]      d2_q,     d2_d;

    logic is_mdu_s;
    logic busy_s;
    logic stall_s;
    logic issue_s;

    // Request decode, stall and issue qualification.
    always_comb begin
        is_mdu_s = bus.d_valid && (bus.d_mdu_op <= OP_MADDU);
        busy_s   = (state_q == ST_BUSY);
        stall_s  = is_mdu_s && busy_s;
        issue_s  = is_mdu_s && !busy_s && !bus.e_hold;
    end

    // Next-state for the MDU drive registers and countdown.
    always_comb begin
        en_d = 1'b0;
        op_d = OP_NOP;
        d1_d = d1_q;
        d2_d = d2_q;
        if (issue_s) begin
            en_d  = op_enables_mdu(bus.d_mdu_op);
            op_d  = bus.d_mdu_op;
            d1_d  = bus.d_rs_val;
            d2_d  = bus.d_rt_val;
            cnt_d = busy_cycles(bus.d_mdu_op);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end
        state_d = (cnt_d != {CNT_W{1'b0}}) ? ST_BUSY : ST_IDLE;
    end

    // State, countdown and MDU drive registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            en_q    <= 1'b0;
            op_q    <= OP_NOP;
            d1_q    <= 32'd0;
            d2_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            op_q    <= op_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
    end

    assign bus.en_mdu  = en_q;
    assign bus.mdu_op  = op_q;
    assign bus.mdu_d1  = d1_q;
    assign bus.mdu_d2  = d2_q;
    assign bus.stall_d = stall_s;
    assign bus.busy    = busy_s;
    assign bus.cnt     = cnt_q;

`ifdef MDU_STALL_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Stall counter wraps naturally at 32 bits.
    always_comb begin
        if (stall_s) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end else begin
            perf_cnt_d = perf_cnt_q;
        end
    end

    // Stall performance counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= 32'd0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_stall_cnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Self-checking bench for mdu_issue_ctrl: directed scenarios followed by random
// traffic, all checked against a behavioural occupancy model.
module tb_mdu_issue_ctrl;

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    mdu_issue_if bus ();
`ifdef MDU_STALL_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    mdu_issue_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef MDU_STALL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining busy cycles plus last MDU drive values
    int          m_rem;
    logic        m_en;
    logic [3:0]  m_op;
    logic [31:0] m_d1;
    logic [31:0] m_d2;
    logic [31:0] m_perf;
    logic        last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rem  = 0;
        m_en   = 1'b0;
        m_op   = 4'd15;
        m_d1   = 32'd0;
        m_d2   = 32'd0;
        m_perf = 32'd0;
    endtask

    // One clock: drive D-stage, check stall before the edge, outputs after it.
    task automatic cycle(input logic v, input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic hold);
        logic ismdu, stall, iss;
        bus.d_valid  = v;
        bus.d_mdu_op = op;
        bus.d_rs_val = rs;
        bus.d_rt_val = rt;
        bus.e_hold   = hold;
        ismdu = v && (op <= 4'd8);
        stall = ismdu && (m_rem > 0);
        iss   = ismdu && (m_rem == 0) && !hold;
        @(negedge clk);
        chk("stall_d", {31'd0, bus.stall_d}, {31'd0, stall});
        last_stall = bus.stall_d;
        if (stall) m_perf = m_perf + 32'd1;
        if (iss) begin
            m_op  = op;
            m_d1  = rs;
            m_d2  = rt;
            m_en  = !(op == 4'd6 || op == 4'd7);
            m_rem = (op < 4'd2) ? 5 : (op < 4'd4) ? 10 : 0;
        end else begin
            m_en  = 1'b0;
            m_op  = 4'd15;
            m_rem = (m_rem > 0) ? m_rem - 1 : 0;
        end
        @(posedge clk);
        #1;
        chk("en_mdu", {31'd0, bus.en_mdu}, {31'd0, m_en});
        chk("mdu_op", {28'd0, bus.mdu_op}, {28'd0, m_op});
        chk("mdu_d1", bus.mdu_d1, m_d1);
        chk("mdu_d2", bus.mdu_d2, m_d2);
        chk("cnt", {27'd0, bus.cnt}, m_rem);
        chk("busy", {31'd0, bus.busy}, {31'd0, (m_rem != 0)});
`ifdef MDU_STALL_PERF_EN
        chk("perf", perf_stall_cnt, m_perf);
`endif
    endtask

    task automatic idle();
        cycle(1'b0, 4'd15, 32'd0, 32'd0, 1'b0);
    endtask

    initial begin
        int n;
        errs   = 0;
        checks = 0;
        last_stall = 1'b0;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        bus.d_valid = 1'b1; bus.d_mdu_op = 4'd0; bus.d_rs_val = 32'd7;
        bus.d_rt_val = 32'd9; bus.e_hold = 1'b0;
        #12;
        chk("rst_cnt", {27'd0, bus.cnt}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_en", {31'd0, bus.en_mdu}, 32'd0);
        chk("rst_op", {28'd0, bus.mdu_op}, 32'd15);
        chk("rst_d1", bus.mdu_d1, 32'd0);
        chk("rst_d2", bus.mdu_d2, 32'd0);
        chk("rst_stall", {31'd0, bus.stall_d}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MULT 3 * -2, then MFLO waits exactly MULT_CYCLES
        cycle(1'b1, 4'd0, 32'd3, 32'hFFFF_FFFE, 1'b0);
        chk("mult_en", {31'd0, bus.en_mdu}, 32'd1);
        chk("mult_d2", bus.mdu_d2, 32'hFFFF_FFFE);
        chk("mult_cnt", {27'd0, bus.cnt}, 32'd5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 4'd7, 32'h11, 32'h22, 1'b0);
            if (!last_stall) break;
            n++;
        end
        chk("mflo_stalls", n, 32'd5);
        chk("mflo_en", {31'd0, bus.en_mdu}, 32'd0);
        chk("mflo_op", {28'd0, bus.mdu_op}, 32'd7);

        // DIVU then DIV waits DIV_CYCLES
        cycle(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1, 4'd2, 32'd50, 32'd5, 1'b0);
            if (!last_stall) break;
            n++;
        end
        chk("div_stalls", n, 32'd10);
        chk("div_reload", {27'd0, bus.cnt}, 32'd10);
        for (int i = 0; i < 10; i++) idle();

        // MTHI, MTLO, MADDU back-to-back
        cycle(1'b1, 4'd4, 32'hA, 32'hB, 1'b0);
        chk("mthi_op", {28'd0, bus.mdu_op}, 32'd4);
        cycle(1'b1, 4'd5, 32'hC, 32'hD, 1'b0);
        chk("mtlo_op", {28'd0, bus.mdu_op}, 32'd5);
        cycle(1'b1, 4'd8, 32'hE, 32'hF, 1'b0);
        chk("maddu_op", {28'd0, bus.mdu_op}, 32'd8);
        chk("maddu_cnt", {27'd0, bus.cnt}, 32'd0);

        // MULT then e_hold during BUSY; countdown keeps running
        cycle(1'b1, 4'd1, 32'd5, 32'd6, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd6, 32'd1, 32'd2, 1'b1);
        idle();
        idle();
        chk("hold_cnt0", {27'd0, bus.cnt}, 32'd0);
        cycle(1'b1, 4'd6, 32'd1, 32'd2, 1'b1);
        chk("hold_blocks", {28'd0, bus.mdu_op}, 32'd15);
        cycle(1'b1, 4'd6, 32'd1, 32'd2, 1'b0);
        chk("hold_issue", {28'd0, bus.mdu_op}, 32'd6);

        // Async reset mid-DIV at cnt=6
        cycle(1'b1, 4'd2, 32'd9, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) idle();
        chk("pre_rst_cnt", {27'd0, bus.cnt}, 32'd6);
        bus.d_valid = 1'b1; bus.d_mdu_op = 4'd0; bus.e_hold = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt", {27'd0, bus.cnt}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_op", {28'd0, bus.mdu_op}, 32'd15);
        chk("mid_rst_stall", {31'd0, bus.stall_d}, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b1, 4'd0, 32'd4, 32'd8, 1'b0);
        chk("post_rst_en", {31'd0, bus.en_mdu}, 32'd1);
        chk("post_rst_op", {28'd0, bus.mdu_op}, 32'd0);

`ifdef MDU_STALL_PERF_EN
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
        chk("perf_five", perf_stall_cnt, 32'd5);
        for (int i = 0; i < 2; i++) idle();
        dut.perf_cnt_q = 32'hFFFF_FFFE;
        m_perf = 32'hFFFF_FFFE;
        cycle(1'b1, 4'd0, 32'd1, 32'd1, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'd6, 32'd0, 32'd0, 1'b0);
        chk("perf_wrap", perf_stall_cnt, 32'd3);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  $urandom, $urandom, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
